weighted_vote_tally: RTL and testbench
======================================

Name: weighted_vote_tally

Overview:
- Sequential, parametrised successor to the single-shot weighted majority voter.
- Accumulates weighted ballots over a multi-cycle voting session with a valid/ready handshake, a one-stage popcount pipeline and a saturating tally.
- Produces a registered pass/fail verdict and the final tally once the session is closed.
- Sits between ballot sources and downstream control logic that consumes a one-pulse-per-session result.

Parameters:
- NP_W, 32, width of normal-voter bit vector, weight 1 per set bit
- VIP_W, 8, width of VIP bit vector
- VIP_WEIGHT, 4, weight per set VIP bit
- VVIP_WEIGHT, 16, weight of the single VVIP bit
- THRESH, 32, verdict passes when tally is strictly greater than THRESH
- CNT_W, 16, tally width; the accumulator saturates at 2^CNT_W-1

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse; opens a new session and clears the tally
- close  in  1  one-cycle pulse; ends the open session
- in_valid  in  1  ballot present
- in_ready  out  1  ballot accepted when in_valid && in_ready
- np  in  NP_W  normal votes
- vip  in  VIP_W  VIP votes
- vvip  in  1  VVIP vote
- busy  out  1  high in OPEN and DRAIN
- res_valid  out  1  single-cycle pulse on entry to DONE
- res  out  1  verdict; held until next start
- total  out  CNT_W  final tally; held until next start

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; stage register, stage valid and accumulator cleared; in_ready=0, busy=0, res_valid=0, res=0, total=0.
- States: IDLE, OPEN, DRAIN, DONE.
- IDLE:
  - start -> OPEN, accumulator cleared.
  - close and in_valid are ignored.
- OPEN:
  - in_ready=1 (registered, derived from state).
  - On a handshake, the stage register captures w = popcount(np) + VIP_WEIGHT*popcount(vip) + VVIP_WEIGHT*vvip.
  - w is computed at a width that cannot overflow; a stage-valid flag is set.
  - The edge after capture: acc = min(acc + w, 2^CNT_W-1).
  - Ballot-to-tally latency is 2 edges. Back-to-back ballots are accepted every cycle (throughput 1/cycle).
- close in OPEN:
  - A ballot handshaked in the same cycle is counted.
  - Next state is DRAIN; in_ready drops the cycle after close.
- DRAIN (exactly 1 cycle): the pending stage value, if any, is added. Then -> DONE.
- DONE entry:
  - total <= acc; res <= (acc > THRESH); res_valid=1 for exactly one cycle.
  - Remains in DONE, holding res and total, until start.
- start:
  - In OPEN, DRAIN or DONE: restart. The stage is flushed without adding, acc is cleared, state goes to OPEN.
  - res and total clear to 0 on start.
  - start and close in the same cycle: start wins.
- Saturation: once acc reaches 2^CNT_W-1 it holds there; res still uses the saturated value.
- in_valid outside OPEN: no handshake, no effect.
- A session with zero ballots gives total=0; res=0 unless the THRESH comparison passes at 0.

Optional Feature:
- Macro: VOTE_VETO_EN.
- When defined:
  - Extra input port veto (1 bit), sampled only on ballot handshakes in OPEN.
  - Any accepted ballot with veto=1 sets a sticky veto flag, cleared by start and reset.
  - In DONE, res = (acc > THRESH) && !veto_flag; total is unaffected.
- When undefined: no veto port, no flag, res as described above.

Test Plan:
- Default params, start, one ballot np=32'hFFFFFFFF, vip=0, vvip=0, close -> res_valid pulse, total=32, res=0 (strict comparison).
- Same ballot plus vip=8'h01 -> total=36, res=1. Also check res_valid appears exactly 3 cycles after the close cycle when close coincides with the ballot.
- Three back-to-back ballots with only vvip=1, close in the cycle of the third ballot -> total=48, res=1. in_ready stays 1 for all three cycles.
- CNT_W=6: five ballots of vip=8'hFF (32 each) -> total=63 (saturated), res=1.
- Reset mid-session: assert rst_n=0 asynchronously while OPEN with acc=20 -> all outputs 0 immediately, state IDLE. A later session with np=1 bit gives total=1.
- VOTE_VETO_EN defined: ballots vvip=1, vvip=1, vvip=1 with veto=1 on the second -> total=48, res=0. The next session without veto -> res=1.

Source files
------------

// File: rtl/weighted_vote_tally.sv
// ---------------------------------------------------------------------------
// weighted_vote_tally
//
// Accumulates weighted ballots over a multi-cycle voting session and reports
// a registered pass/fail verdict together with the final tally once the
// session is closed.
//
// Each accepted ballot is worth
//    popcount(np) + VIP_WEIGHT*popcount(vip) + VVIP_WEIGHT*vvip
// and is registered in a one-stage popcount pipeline. The edge after capture
// adds it into a saturating tally accumulator.
//
// Ports:
//    clk       - clock, all state updates on the rising edge
//    rst_n     - asynchronous active-low reset
//    start     - one-cycle pulse, opens a new session and clears the tally
//    close     - one-cycle pulse, ends the open session
//    in_valid  - ballot present
//    in_ready  - ballot accepted when in_valid && in_ready (high in OPEN)
//    np        - normal votes, weight 1 per set bit
//    vip       - VIP votes, VIP_WEIGHT per set bit
//    vvip      - single VVIP vote, weight VVIP_WEIGHT
//    veto      - (VOTE_VETO_EN only) veto flag sampled on ballot handshakes
//    busy      - high while OPEN or DRAIN
//    res_valid - single-cycle pulse once the result is available
//    res       - verdict (tally > THRESH), held until next start
//    total     - final tally, held until next start
//
// Optional feature macro: VOTE_VETO_EN
//    Adds the veto input. Any accepted ballot with veto=1 sets a sticky flag
//    that forces the verdict to 0; the tally itself is unaffected.
// ---------------------------------------------------------------------------
module weighted_vote_tally #(
   parameter int NP_W        = 32,
   parameter int VIP_W       = 8,
   parameter int VIP_WEIGHT  = 4,
   parameter int VVIP_WEIGHT = 16,
   parameter int THRESH      = 32,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             close,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NP_W-1:0]  np,
   input  logic [VIP_W-1:0] vip,
   input  logic             vvip,
`ifdef VOTE_VETO_EN
   input  logic             veto,
`endif
   output logic             busy,
   output logic             res_valid,
   output logic             res,
   output logic [CNT_W-1:0] total
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OPEN  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   // Ballot weight width sized for the largest possible ballot.
   localparam int W_MAX = NP_W + VIP_WEIGHT * VIP_W + VVIP_WEIGHT;
   localparam int W_W   = $clog2(W_MAX + 1);
   // One spare bit above the wider operand so acc + stage never wraps.
   localparam int SUM_W = ((CNT_W > W_W) ? CNT_W : W_W) + 1;
   // Verdict comparison width wide enough for both acc and THRESH.
   localparam int CMP_W = (CNT_W > 32) ? (CNT_W + 1) : 33;

   localparam logic [CNT_W-1:0] ACC_MAX = '1;

   logic [1:0]       state;
   logic [W_W-1:0]   stage;
   logic             stage_valid;
   logic [CNT_W-1:0] acc;
   logic             done_pend;
   logic             verdict;

   logic [W_W-1:0]   np_cnt;
   logic [W_W-1:0]   vip_cnt;
   logic [W_W-1:0]   weight;
   logic [SUM_W-1:0] acc_sum;
   logic [CNT_W-1:0] acc_sat;
   logic             handshake;

   // in_ready and busy decode the state register directly, so they change
   // only on clock edges (or immediately on reset).
   assign in_ready  = (state == OPEN);
   assign busy      = (state == OPEN) || (state == DRAIN);
   assign handshake = in_valid && in_ready;

   always_comb begin
      np_cnt  = '0;
      vip_cnt = '0;
      for (int i = 0; i < NP_W; i++) begin
         np_cnt = np_cnt + W_W'(np[i]);
      end
      for (int j = 0; j < VIP_W; j++) begin
         vip_cnt = vip_cnt + W_W'(vip[j]);
      end
      weight = np_cnt + W_W'(VIP_WEIGHT) * vip_cnt
             + (vvip ? W_W'(VVIP_WEIGHT) : W_W'(0));
   end

   // Saturating add of the pending stage value into the accumulator.
   always_comb begin
      acc_sum = SUM_W'(acc) + SUM_W'(stage);
      acc_sat = (acc_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : acc_sum[CNT_W-1:0];
   end

`ifdef VOTE_VETO_EN
   logic veto_flag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         veto_flag <= 1'b0;
      end else if (start) begin
         veto_flag <= 1'b0;
      end else if (handshake && veto) begin
         veto_flag <= 1'b1;
      end
   end

   assign verdict = (CMP_W'(acc) > CMP_W'(THRESH)) && !veto_flag;
`else
   assign verdict = (CMP_W'(acc) > CMP_W'(THRESH));
`endif

   // Session control. start restarts from any state and flushes the stage
   // without adding it; it also wins over a simultaneous close. The DRAIN
   // state folds in the last pending ballot, and the first DONE cycle
   // publishes the then-final accumulator (done_pend marks that cycle).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         stage       <= '0;
         stage_valid <= 1'b0;
         acc         <= '0;
         done_pend   <= 1'b0;
         res_valid   <= 1'b0;
         res         <= 1'b0;
         total       <= '0;
      end else if (start) begin
         state       <= OPEN;
         stage       <= '0;
         stage_valid <= 1'b0;
         acc         <= '0;
         done_pend   <= 1'b0;
         res_valid   <= 1'b0;
         res         <= 1'b0;
         total       <= '0;
      end else begin
         res_valid <= 1'b0;
         case (state)
            OPEN: begin
               if (stage_valid) begin
                  acc <= acc_sat;
               end
               stage_valid <= handshake;
               if (handshake) begin
                  stage <= weight;
               end
               if (close) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (stage_valid) begin
                  acc <= acc_sat;
               end
               stage_valid <= 1'b0;
               done_pend   <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (done_pend) begin
                  total     <= acc;
                  res       <= verdict;
                  res_valid <= 1'b1;
                  done_pend <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weighted_vote_tally.sv
// ---------------------------------------------------------------------------
// tb_weighted_vote_tally
//
// Self-checking bench for weighted_vote_tally. Two instances share the same
// stimulus: one with default parameters and one with a 6-bit tally so that
// saturation is reachable in a few ballots. Expected tallies come from a
// session-level model: the sum of ballot weights for the session, clipped to
// the tally maximum, compared against the threshold.
// ---------------------------------------------------------------------------
module tb_weighted_vote_tally;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        close;
   logic        in_valid;
   logic [31:0] np;
   logic [7:0]  vip;
   logic        vvip;
`ifdef VOTE_VETO_EN
   logic        veto;
`endif

   logic        in_ready, busy, res_valid, res;
   logic [15:0] total;
   logic        in_ready_s, busy_s, res_valid_s, res_s;
   logic [5:0]  total_s;

   int nTests = 0;
   int nFail  = 0;

   logic [31:0] bNp[$];
   logic [7:0]  bVip[$];
   bit          bVvip[$];
   bit          bVeto[$];

   weighted_vote_tally dut (
      .clk(clk), .rst_n(rst_n), .start(start), .close(close),
      .in_valid(in_valid), .in_ready(in_ready),
      .np(np), .vip(vip), .vvip(vvip),
`ifdef VOTE_VETO_EN
      .veto(veto),
`endif
      .busy(busy), .res_valid(res_valid), .res(res), .total(total)
   );

   weighted_vote_tally #(.CNT_W(6)) dutSmall (
      .clk(clk), .rst_n(rst_n), .start(start), .close(close),
      .in_valid(in_valid), .in_ready(in_ready_s),
      .np(np), .vip(vip), .vvip(vvip),
`ifdef VOTE_VETO_EN
      .veto(veto),
`endif
      .busy(busy_s), .res_valid(res_valid_s), .res(res_s), .total(total_s)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic addBallot(input logic [31:0] n, input logic [7:0] v, input bit vv, input bit vt);
      bNp.push_back(n);
      bVip.push_back(v);
      bVvip.push_back(vv);
      bVeto.push_back(vt);
   endtask

   // Runs one full session with the queued ballots and checks the result.
   task automatic applyStimulus(input bit closeWithLast, input bit gaps);
      int  sum;
      bit  vetoed;
      int  cycles;
      int  expDef;
      int  expSmall;
      int  n;
      sum    = 0;
      vetoed = 0;
      n      = bNp.size();

      start    = 1'b1;
      close    = 1'($urandom_range(0, 1));
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      close = 1'b0;
      checkOutput("start_busy", 32'(busy), 1);
      checkOutput("start_ready", 32'(in_ready), 1);
      checkOutput("start_total", 32'(total), 0);
      checkOutput("start_res", 32'(res), 0);
      checkOutput("start_total_s", 32'(total_s), 0);

      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            np       = $urandom();
            vip      = 8'($urandom());
            vvip     = 1'($urandom_range(0, 1));
            tick();
         end
         in_valid = 1'b1;
         np       = bNp[i];
         vip      = bVip[i];
         vvip     = bVvip[i];
`ifdef VOTE_VETO_EN
         veto     = bVeto[i];
         if (bVeto[i]) vetoed = 1;
`endif
         close    = closeWithLast && (i == n - 1);
         checkOutput("ballot_ready", 32'(in_ready), 1);
         sum += $countones(bNp[i]) + 4 * $countones(bVip[i]) + (bVvip[i] ? 16 : 0);
         tick();
      end
      in_valid = 1'b0;
      close    = 1'b0;
`ifdef VOTE_VETO_EN
      veto     = 1'b0;
`endif
      if (!closeWithLast || n == 0) begin
         close = 1'b1;
         tick();
         close = 1'b0;
      end

      checkOutput("drain_ready", 32'(in_ready), 0);
      checkOutput("drain_busy", 32'(busy), 1);
      checkOutput("drain_no_valid", 32'(res_valid), 0);

      cycles = 1;
      while (!res_valid && cycles < 8) begin
         tick();
         cycles++;
      end
      checkOutput("res_latency", 32'(cycles), 3);

      expDef   = (sum > 65535) ? 65535 : sum;
      expSmall = (sum > 63) ? 63 : sum;
      checkOutput("total", 32'(total), 32'(expDef));
      checkOutput("res", 32'(res), 32'((expDef > 32) && !vetoed));
      checkOutput("res_valid_s", 32'(res_valid_s), 1);
      checkOutput("total_s", 32'(total_s), 32'(expSmall));
      checkOutput("res_s", 32'(res_s), 32'((expSmall > 32) && !vetoed));

      in_valid = 1'b1;
      np       = $urandom();
      tick();
      in_valid = 1'b0;
      checkOutput("pulse_end", 32'(res_valid), 0);
      checkOutput("hold_total", 32'(total), 32'(expDef));
      checkOutput("hold_res", 32'(res), 32'((expDef > 32) && !vetoed));
      checkOutput("done_ready", 32'(in_ready), 0);
      checkOutput("done_busy", 32'(busy), 0);

      bNp.delete();
      bVip.delete();
      bVvip.delete();
      bVeto.delete();
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      close    = 1'b0;
      in_valid = 1'b0;
      np       = '0;
      vip      = '0;
      vvip     = 1'b0;
`ifdef VOTE_VETO_EN
      veto     = 1'b0;
`endif
      #12;
      checkOutput("rst_ready", 32'(in_ready), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_res_valid", 32'(res_valid), 0);
      checkOutput("rst_res", 32'(res), 0);
      checkOutput("rst_total", 32'(total), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Ballots and close in IDLE are ignored.
      in_valid = 1'b1;
      np       = 32'hFFFFFFFF;
      close    = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      close    = 1'b0;
      checkOutput("idle_busy", 32'(busy), 0);
      checkOutput("idle_res_valid", 32'(res_valid), 0);

      // 32 normal votes: strict comparison fails at exactly THRESH.
      addBallot(32'hFFFFFFFF, 8'h00, 0, 0);
      applyStimulus(0, 0);

      // 32 + 4 = 36 with close on the ballot cycle.
      addBallot(32'hFFFFFFFF, 8'h01, 0, 0);
      applyStimulus(1, 0);

      // Three back-to-back VVIP ballots, close with the third.
      for (int i = 0; i < 3; i++) addBallot(32'h0, 8'h00, 1, 0);
      applyStimulus(1, 0);

      // Five full-VIP ballots: 160, saturates the 6-bit instance at 63.
      for (int i = 0; i < 5; i++) addBallot(32'h0, 8'hFF, 0, 0);
      applyStimulus(0, 0);

      // Empty session.
      applyStimulus(0, 0);

      // Restart while a ballot is pending in the stage: it must be dropped.
      start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      np       = 32'hFFFFFFFF;
      vip      = 8'hFF;
      vvip     = 1'b1;
      tick();
      in_valid = 1'b0;
      addBallot(32'h0, 8'h01, 0, 0);
      applyStimulus(1, 0);

      // Asynchronous reset mid-session with acc = 20.
      start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      np       = 32'h000FFFFF;
      vip      = 8'h00;
      vvip     = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_ready", 32'(in_ready), 0);
      checkOutput("arst_busy", 32'(busy), 0);
      checkOutput("arst_res_valid", 32'(res_valid), 0);
      checkOutput("arst_res", 32'(res), 0);
      checkOutput("arst_total", 32'(total), 0);
      checkOutput("arst_busy_s", 32'(busy_s), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_busy", 32'(busy), 0);
      addBallot(32'h00000001, 8'h00, 0, 0);
      applyStimulus(0, 0);

`ifdef VOTE_VETO_EN
      // Veto on the second of three VVIP ballots blocks the verdict.
      addBallot(32'h0, 8'h00, 1, 0);
      addBallot(32'h0, 8'h00, 1, 1);
      addBallot(32'h0, 8'h00, 1, 0);
      applyStimulus(0, 0);
      for (int i = 0; i < 3; i++) addBallot(32'h0, 8'h00, 1, 0);
      applyStimulus(0, 0);
`endif

      // Randomized sessions with idle gaps between ballots.
      for (int s = 0; s < 20; s++) begin
         int nb;
         nb = $urandom_range(0, 6);
         for (int i = 0; i < nb; i++) begin
            addBallot($urandom() & ((s % 2 == 0) ? 32'h0F0F0F0F : 32'hFFFFFFFF),
                      8'($urandom()), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0));
         end
         applyStimulus(1'($urandom_range(0, 1)), 1);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
